// File: rtl/div_iter_if.sv
// Issue-queue / CDB bundle for the iterative divide unit.
// The master side is the issue queue plus the CDB arbiter; the slave side is the divider.
interface div_iter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [TAG_W-1:0] rd_tag;
    logic [1:0]       div_op;
    logic             flush;
    logic             cdb_grant;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [WIDTH-1:0] cdb_result;
    logic             cdb_branch;
    logic             issue_done;

    modport master (
        output issue_valid, rs1_data, rs2_data, rd_tag, div_op, flush, cdb_grant,
        input  issue_ready, cdb_valid, cdb_tag, cdb_result, cdb_branch, issue_done
    );

    modport slave (
        input  issue_valid, rs1_data, rs2_data, rd_tag, div_op, flush, cdb_grant,
        output issue_ready, cdb_valid, cdb_tag, cdb_result, cdb_branch, issue_done
    );
endinterface

// File: rtl/div_iter_unit.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring iteration on magnitudes,
// with a one-cycle result-formatting stage before the result is held on the CDB.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_iter_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [TAG_W-1:0] tag_q;
    logic             negq_q, negr_q, rem_sel_q, spec_q;
    logic             cdb_valid_q;
    logic [TAG_W-1:0] cdb_tag_q;
    logic [WIDTH-1:0] cdb_result_q;

    logic             signed_op, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, spec_res;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_d, quo_d, res_d;

    always_comb begin
        signed_op = ~bus.div_op[0];
        a_neg     = signed_op & bus.rs1_data[WIDTH-1];
        b_neg     = signed_op & bus.rs2_data[WIDTH-1];
        a_mag     = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag     = b_neg ? -bus.rs2_data : bus.rs2_data;
        div_zero  = (bus.rs2_data == '0);
        ovf       = signed_op && (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
        if (div_zero)
            spec_res = bus.div_op[1] ? bus.rs1_data : '1;
        else
            spec_res = bus.div_op[1] ? '0 : bus.rs1_data;
    end

    // Trial subtraction is one bit wider so its MSB is the restore decision.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        if (spec_q)
            res_d = quo_q;
        else if (rem_sel_q)
            res_d = negr_q ? -rem_q : rem_q;
        else
            res_d = negq_q ? -quo_q : quo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            tag_q        <= '0;
            negq_q       <= 1'b0;
            negr_q       <= 1'b0;
            rem_sel_q    <= 1'b0;
            spec_q       <= 1'b0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_result_q <= '0;
        end else if (bus.flush) begin
            // A simultaneous grant still retires: issue_done is decoded from this cycle's state.
            state_q      <= IDLE;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.issue_valid) begin
                    tag_q     <= bus.rd_tag;
                    rem_sel_q <= bus.div_op[1];
                    negq_q    <= a_neg ^ b_neg;
                    negr_q    <= a_neg;
                    rem_q     <= '0;
                    dvs_q     <= b_mag;
                    cnt_q     <= CNT_W'(WIDTH-1);
                    if (div_zero || ovf) begin
                        spec_q  <= 1'b1;
                        quo_q   <= spec_res;
                        state_q <= FIN;
                    end else begin
                        spec_q  <= 1'b0;
                        quo_q   <= a_mag;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0)
                        state_q <= FIN;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                FIN: begin
                    cdb_valid_q  <= 1'b1;
                    cdb_tag_q    <= tag_q;
                    cdb_result_q <= res_d;
                    state_q      <= DONE;
                end
                DONE: if (bus.cdb_grant) begin
                    cdb_valid_q  <= 1'b0;
                    cdb_tag_q    <= '0;
                    cdb_result_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.issue_ready = (state_q == IDLE);
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_result  = cdb_result_q;
    assign bus.cdb_branch  = 1'b0;
    assign bus.issue_done  = cdb_valid_q & bus.cdb_grant;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: vector table with grant tied high, then hold,
// flush, reset and narrow-width sequences.
module tb_div_iter_unit;
    logic clk, rst;
    int   n_pass = 0, n_tot = 0;

    div_iter_if #(.WIDTH(32), .TAG_W(6)) bus ();
    div_iter_if #(.WIDTH(8),  .TAG_W(6)) bus8 ();

    div_iter_unit #(.WIDTH(32), .TAG_W(6)) dut  (.clk(clk), .rst(rst), .bus(bus));
    div_iter_unit #(.WIDTH(8),  .TAG_W(6)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [5:0]  tag;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b;
        logic [7:0] res;
        int         lat;
    } vec8_t;

    vec_t  vecs[16];
    vec8_t v8[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] tag);
        int w = 0;
        @(negedge clk);
        while (!bus.issue_ready && w < 100) begin @(negedge clk); w++; end
        chk("ready_before_issue", bus.issue_ready, 1);
        bus.div_op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_tag = tag;
        bus.issue_valid = 1'b1;
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
    endtask

    // lat = number of edges after the accept edge when cdb_valid is first seen
    task automatic wait_valid32(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (bus.cdb_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic watch32(input int cycles, output int nv, output int nd);
        nv = 0; nd = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.cdb_valid)  nv++;
            if (bus.issue_done) nd++;
        end
    endtask

    initial begin
        int lat, nv, nd, bad;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          6'd5,  32'd14,         33};
        vecs[1]  = '{2'b00, 32'hFFFFFFEC,   32'd3,          6'd1,  32'hFFFFFFFA,   33};
        vecs[2]  = '{2'b10, 32'hFFFFFFEC,   32'd3,          6'd2,  32'hFFFFFFFE,   33};
        vecs[3]  = '{2'b11, 32'hFFFFFFFF,   32'd16,         6'd3,  32'd15,         33};
        vecs[4]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   6'd4,  32'h80000000,   1};
        vecs[5]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   6'd6,  32'd0,          1};
        vecs[6]  = '{2'b01, 32'd9,          32'd0,          6'd7,  32'hFFFFFFFF,   1};
        vecs[7]  = '{2'b11, 32'd9,          32'd0,          6'd8,  32'd9,          1};
        vecs[8]  = '{2'b00, 32'd7,          32'd0,          6'd9,  32'hFFFFFFFF,   1};
        vecs[9]  = '{2'b10, 32'hFFFFFFFB,   32'd0,          6'd10, 32'hFFFFFFFB,   1};
        vecs[10] = '{2'b00, 32'd20,         32'hFFFFFFFD,   6'd11, 32'hFFFFFFFA,   33};
        vecs[11] = '{2'b10, 32'd20,         32'hFFFFFFFD,   6'd12, 32'd2,          33};
        vecs[12] = '{2'b00, 32'hFFFFFFEC,   32'hFFFFFFFD,   6'd13, 32'd6,          33};
        vecs[13] = '{2'b10, 32'hFFFFFFEC,   32'hFFFFFFFD,   6'd14, 32'hFFFFFFFE,   33};
        vecs[14] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   6'd15, 32'd0,          33};
        vecs[15] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   6'd63, 32'h80000000,   33};

        v8[0] = '{2'b01, 8'd200, 8'd9,  8'd22,  9};
        v8[1] = '{2'b11, 8'd200, 8'd9,  8'd2,   9};
        v8[2] = '{2'b00, 8'h9C,  8'd7,  8'hF2,  9};
        v8[3] = '{2'b00, 8'h80,  8'hFF, 8'h80,  1};

        bus.issue_valid = 0; bus.rs1_data = 0; bus.rs2_data = 0; bus.rd_tag = 0;
        bus.div_op = 0; bus.flush = 0; bus.cdb_grant = 1;
        bus8.issue_valid = 0; bus8.rs1_data = 0; bus8.rs2_data = 0; bus8.rd_tag = 0;
        bus8.div_op = 0; bus8.flush = 0; bus8.cdb_grant = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        @(negedge clk);
        chk("rst_ready",  bus.issue_ready, 1);
        chk("rst_valid",  bus.cdb_valid, 0);
        chk("rst_tag",    bus.cdb_tag, 0);
        chk("rst_result", bus.cdb_result, 0);
        chk("rst_done",   bus.issue_done, 0);
        chk("rst_branch", bus.cdb_branch, 0);

        for (int i = 0; i < 16; i++) begin
            issue32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_valid32(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_result", i), bus.cdb_result, vecs[i].res);
            chk($sformatf("v%0d_tag", i), bus.cdb_tag, vecs[i].tag);
            chk($sformatf("v%0d_done", i), bus.issue_done, 1);
            chk($sformatf("v%0d_branch", i), bus.cdb_branch, 0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_ready_after", i), bus.issue_ready, 1);
            chk($sformatf("v%0d_valid_after", i), bus.cdb_valid, 0);
            chk($sformatf("v%0d_done_after", i), bus.issue_done, 0);
            chk($sformatf("v%0d_result_zero", i), bus.cdb_result, 0);
        end

        // Hold result without grant while a second op waits at the issue port
        bus.cdb_grant = 0;
        issue32(2'b01, 32'd100, 32'd7, 6'd9);
        wait_valid32(lat);
        chk("hold_latency", lat, 33);
        bus.div_op = 2'b01; bus.rs1_data = 32'd50; bus.rs2_data = 32'd5; bus.rd_tag = 6'd3;
        bus.issue_valid = 1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 6'd9 || bus.cdb_result !== 32'd14 ||
                bus.issue_ready !== 1'b0 || bus.issue_done !== 1'b0) bad++;
        end
        chk("hold_stable", bad, 0);
        bus.cdb_grant = 1; #1;
        chk("hold_grant_done", bus.issue_done, 1);
        @(posedge clk); #1 bus.cdb_grant = 0;
        @(negedge clk);
        chk("hold_ready_next", bus.issue_ready, 1);
        chk("hold_done_single", bus.issue_done, 0);
        chk("hold_valid_off", bus.cdb_valid, 0);
        @(posedge clk); #1;
        bus.issue_valid = 0; bus.cdb_grant = 1;
        wait_valid32(lat);
        chk("second_latency", lat, 33);
        chk("second_result", bus.cdb_result, 10);
        chk("second_tag", bus.cdb_tag, 3);
        @(posedge clk);

        // Flush in the middle of the iteration
        issue32(2'b01, 32'd100, 32'd7, 6'd20);
        repeat (12) @(posedge clk);
        @(negedge clk) bus.flush = 1;
        @(posedge clk); #1 bus.flush = 0;
        @(negedge clk);
        chk("flush_calc_ready", bus.issue_ready, 1);
        chk("flush_calc_valid", bus.cdb_valid, 0);
        watch32(40, nv, nd);
        chk("flush_calc_no_valid", nv, 0);
        chk("flush_calc_no_done", nd, 0);

        // Flush together with issue_valid in IDLE: nothing accepted
        @(negedge clk);
        bus.div_op = 2'b01; bus.rs1_data = 32'd9; bus.rs2_data = 32'd0; bus.rd_tag = 6'd21;
        bus.issue_valid = 1; bus.flush = 1;
        @(posedge clk); #1 bus.issue_valid = 0; bus.flush = 0;
        watch32(10, nv, nd);
        chk("flush_idle_no_valid", nv, 0);
        chk("flush_idle_ready", bus.issue_ready, 1);

        // Flush together with grant in DONE: grant wins
        bus.cdb_grant = 0;
        issue32(2'b01, 32'd9, 32'd0, 6'd22);
        wait_valid32(lat);
        chk("flush_done_latency", lat, 1);
        bus.flush = 1; bus.cdb_grant = 1; #1;
        chk("flush_done_pulse", bus.issue_done, 1);
        chk("flush_done_result", bus.cdb_result, 32'hFFFFFFFF);
        @(posedge clk); #1 bus.flush = 0;
        @(negedge clk);
        chk("flush_done_valid_off", bus.cdb_valid, 0);
        chk("flush_done_ready", bus.issue_ready, 1);
        chk("flush_done_done_off", bus.issue_done, 0);

        // Reset during the iteration
        issue32(2'b01, 32'd100, 32'd7, 6'd30);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_calc_ready",  bus.issue_ready, 1);
        chk("rst_calc_valid",  bus.cdb_valid, 0);
        chk("rst_calc_tag",    bus.cdb_tag, 0);
        chk("rst_calc_result", bus.cdb_result, 0);
        chk("rst_calc_done",   bus.issue_done, 0);
        watch32(40, nv, nd);
        chk("rst_calc_no_valid", nv, 0);

        // Narrow instance: WIDTH=8
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus8.div_op = v8[i].op; bus8.rs1_data = v8[i].a; bus8.rs2_data = v8[i].b;
            bus8.rd_tag = 6'(40 + i); bus8.issue_valid = 1;
            @(posedge clk); #1 bus8.issue_valid = 0;
            lat = 0;
            while (lat < 100) begin
                @(negedge clk);
                if (bus8.cdb_valid) break;
                @(posedge clk);
                lat++;
            end
            chk($sformatf("w8_%0d_latency", i), lat, v8[i].lat);
            chk($sformatf("w8_%0d_result", i), bus8.cdb_result, v8[i].res);
            chk($sformatf("w8_%0d_tag", i), bus8.cdb_tag, 40 + i);
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
